// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage MIPS pipeline: EX operand forwarding,
// load-use interlock, branch flush and whole-pipeline freeze while data memory is busy.
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt_dst,
  input  logic              exm_reg_write,
  input  logic [REG_AW-1:0] exm_wr_reg,
  input  logic              mwb_reg_write,
  input  logic [REG_AW-1:0] mwb_wr_reg,
  input  logic              pc_src,
  input  logic              mem_busy,
  output logic [1:0]        forward_a_sel,
  output logic [1:0]        forward_b_sel,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  flush_count
);

  localparam int unsigned WaitW = ($clog2(MAX_WAIT) > 0) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {StRun, StWait, StErr} state_e;

  state_e             state_q, state_d;
  logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
  logic               pend_flush_q, pend_flush_d;
  logic [CNT_W-1:0]   stall_q, stall_d;
  logic [CNT_W-1:0]   flush_q, flush_d;
  logic               lu;

  always_comb begin
    forward_a_sel = 2'b00;
    forward_b_sel = 2'b00;
    if (exm_reg_write && exm_wr_reg != '0 && exm_wr_reg == ex_rs) begin
      forward_a_sel = 2'b10;
    end else if (mwb_reg_write && mwb_wr_reg != '0 && mwb_wr_reg == ex_rs) begin
      forward_a_sel = 2'b01;
    end
    if (exm_reg_write && exm_wr_reg != '0 && exm_wr_reg == ex_rt) begin
      forward_b_sel = 2'b10;
    end else if (mwb_reg_write && mwb_wr_reg != '0 && mwb_wr_reg == ex_rt) begin
      forward_b_sel = 2'b01;
    end
  end

  assign lu = ex_mem_read && (ex_rt_dst != '0) && (ex_rt_dst == id_rs || ex_rt_dst == id_rt);

  // WAIT releases combinationally in its first non-busy cycle, so it shares RUN's output logic.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    pend_flush_d = pend_flush_q;
    pc_en        = 1'b0;
    if_id_en     = 1'b0;
    id_ex_en     = 1'b0;
    ex_mem_en    = 1'b0;
    mem_wb_en    = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    unique case (state_q)
      StRun, StWait: begin
        if (mem_busy) begin
          if (pc_src) pend_flush_d = 1'b1;
          if (wait_cnt_q == WaitLast) begin
            state_d = StErr;
          end else begin
            state_d    = StWait;
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end else begin
          state_d    = StRun;
          wait_cnt_d = '0;
          pc_en      = 1'b1;
          if_id_en   = 1'b1;
          id_ex_en   = 1'b1;
          ex_mem_en  = 1'b1;
          mem_wb_en  = 1'b1;
          if (pc_src || pend_flush_q) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            pend_flush_d = 1'b0;
          end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!pc_en && state_q != StErr && stall_q != '1) stall_d = stall_q + CNT_W'(1);
    if (if_id_flush && flush_q != '1) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRun;
      wait_cnt_q   <= '0;
      pend_flush_q <= 1'b0;
      stall_q      <= '0;
      flush_q      <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pend_flush_q <= pend_flush_d;
      stall_q      <= stall_d;
      flush_q      <= flush_d;
    end
  end

  assign mem_timeout = (state_q == StErr);
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_hazard_ctrl;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int MW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] id_rs, id_rt, ex_rs, ex_rt, ex_rt_dst, exm_wr_reg, mwb_wr_reg;
  logic          ex_mem_read, exm_reg_write, mwb_reg_write, pc_src, mem_busy;
  logic [1:0]    forward_a_sel, forward_b_sel;
  logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_timeout;
  logic [CW-1:0] stall_count, flush_count;

  hazard_ctrl #(.REG_AW(AW), .CNT_W(CW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_mem_read(ex_mem_read), .ex_rt_dst(ex_rt_dst),
    .exm_reg_write(exm_reg_write), .exm_wr_reg(exm_wr_reg),
    .mwb_reg_write(mwb_reg_write), .mwb_wr_reg(mwb_wr_reg),
    .pc_src(pc_src), .mem_busy(mem_busy),
    .forward_a_sel(forward_a_sel), .forward_b_sel(forward_b_sel),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .mem_timeout(mem_timeout), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: count consecutive busy cycles, remember a branch seen while frozen.
  bit m_err  = 1'b0;
  bit m_pend = 1'b0;
  int m_busy_run = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic int sat_inc(input int v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  function automatic int fwd(input logic [AW-1:0] src);
    if (exm_reg_write && exm_wr_reg != 0 && exm_wr_reg == src) return 2;
    if (mwb_reg_write && mwb_wr_reg != 0 && mwb_wr_reg == src) return 1;
    return 0;
  endfunction

  function automatic bit lu_now();
    return ex_mem_read && ex_rt_dst != 0 && (ex_rt_dst == id_rs || ex_rt_dst == id_rt);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_err <= 1'b0; m_pend <= 1'b0; m_busy_run <= 0; m_stall <= 0; m_flush <= 0;
    end else if (!m_err) begin
      if (mem_busy) begin
        if (pc_src) m_pend <= 1'b1;
        m_stall    <= sat_inc(m_stall);
        m_busy_run <= m_busy_run + 1;
        if (m_busy_run + 1 >= MW) m_err <= 1'b1;
      end else begin
        m_busy_run <= 0;
        if (pc_src || m_pend) begin
          m_flush <= sat_inc(m_flush);
          m_pend  <= 1'b0;
        end else if (lu_now()) begin
          m_stall <= sat_inc(m_stall);
        end
      end
    end
  end

  always @(negedge clk) begin
    bit go, br, l;
    go = !m_err && !mem_busy;
    br = go && (pc_src || m_pend);
    l  = lu_now();
    chk("forward_a_sel", int'(forward_a_sel), fwd(ex_rs));
    chk("forward_b_sel", int'(forward_b_sel), fwd(ex_rt));
    chk("pc_en", int'(pc_en), int'(go && (!l || br)));
    chk("if_id_en", int'(if_id_en), int'(go && (!l || br)));
    chk("id_ex_en", int'(id_ex_en), int'(go));
    chk("ex_mem_en", int'(ex_mem_en), int'(go));
    chk("mem_wb_en", int'(mem_wb_en), int'(go));
    chk("if_id_flush", int'(if_id_flush), int'(br));
    chk("id_ex_flush", int'(id_ex_flush), int'(br || (go && l)));
    chk("ex_mem_flush", int'(ex_mem_flush), int'(br));
    chk("mem_timeout", int'(mem_timeout), int'(m_err));
    chk("stall_count", int'(stall_count), m_stall);
    chk("flush_count", int'(flush_count), m_flush);
  end

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rs = '0; ex_rt = '0; ex_rt_dst = '0;
    exm_wr_reg = '0; mwb_wr_reg = '0; ex_mem_read = 1'b0; exm_reg_write = 1'b0;
    mwb_reg_write = 1'b0; pc_src = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int busy_left = 0;

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("reset pc_en", int'(pc_en), 1);
    chk("reset mem_wb_en", int'(mem_wb_en), 1);
    chk("reset id_ex_flush", int'(id_ex_flush), 0);
    chk("reset forward_a_sel", int'(forward_a_sel), 0);
    chk("reset stall_count", int'(stall_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Forwarding priority and register 0
    ex_rs = 5'd3; exm_reg_write = 1'b1; exm_wr_reg = 5'd3;
    mwb_reg_write = 1'b1; mwb_wr_reg = 5'd3;
    @(negedge clk); chk("fwd exm priority", int'(forward_a_sel), 2);
    step(); exm_reg_write = 1'b0;
    @(negedge clk); chk("fwd mwb", int'(forward_a_sel), 1);
    step(); mwb_wr_reg = 5'd0;
    @(negedge clk); chk("fwd r0 never", int'(forward_a_sel), 0);
    step(); idle(); ex_rt = 5'd7; mwb_reg_write = 1'b1; mwb_wr_reg = 5'd7;
    @(negedge clk); chk("fwd b mwb", int'(forward_b_sel), 1);

    // Load-use: one bubble
    step(); idle(); ex_mem_read = 1'b1; ex_rt_dst = 5'd5; id_rt = 5'd5;
    @(negedge clk);
    chk("lu pc_en", int'(pc_en), 0);
    chk("lu if_id_en", int'(if_id_en), 0);
    chk("lu id_ex_flush", int'(id_ex_flush), 1);
    step(); idle();
    @(negedge clk);
    chk("lu stall_count", int'(stall_count), 1);
    chk("lu released pc_en", int'(pc_en), 1);

    // Branch flush, and flush overriding load-use
    step(); pc_src = 1'b1;
    @(negedge clk);
    chk("br if_id_flush", int'(if_id_flush), 1);
    chk("br ex_mem_flush", int'(ex_mem_flush), 1);
    step(); ex_mem_read = 1'b1; ex_rt_dst = 5'd6; id_rs = 5'd6;
    @(negedge clk);
    chk("br+lu pc_en", int'(pc_en), 1);
    chk("br+lu flush_count", int'(flush_count), 1);
    step(); idle();
    @(negedge clk);
    chk("br flush_count", int'(flush_count), 2);
    chk("br stall_count", int'(stall_count), 1);

    // Memory freeze with a branch arriving mid-freeze
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1'b1;
      pc_src = (i == 1);
      @(negedge clk);
      chk("freeze pc_en", int'(pc_en), 0);
      chk("freeze mem_wb_en", int'(mem_wb_en), 0);
      chk("freeze if_id_flush", int'(if_id_flush), 0);
      step();
    end
    idle();
    @(negedge clk);
    chk("unfreeze if_id_flush", int'(if_id_flush), 1);
    chk("unfreeze pc_en", int'(pc_en), 1);
    chk("freeze stall_count", int'(stall_count), 4);
    step();
    @(negedge clk);
    chk("freeze flush_count", int'(flush_count), 1);
    chk("after flush if_id_flush", int'(if_id_flush), 0);

    // Timeout after MAX_WAIT busy cycles; async reset leaves ERR
    do_reset();
    mem_busy = 1'b1;
    for (int i = 0; i < MW; i++) begin
      @(negedge clk);
      chk("pre-timeout mem_timeout", int'(mem_timeout), 0);
      step();
    end
    @(negedge clk);
    chk("timeout mem_timeout", int'(mem_timeout), 1);
    chk("timeout pc_en", int'(pc_en), 0);
    chk("timeout stall_count", int'(stall_count), MW);
    step(); mem_busy = 1'b0;
    @(negedge clk);
    chk("err sticky", int'(mem_timeout), 1);
    chk("err id_ex_en", int'(id_ex_en), 0);
    chk("err stall frozen", int'(stall_count), MW);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst mem_timeout", int'(mem_timeout), 0);
    chk("async rst stall_count", int'(stall_count), 0);
    chk("async rst pc_en", int'(pc_en), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Saturation: 20 load-use stalls on a 4-bit counter
    ex_mem_read = 1'b1; ex_rt_dst = 5'd4; id_rs = 5'd4;
    repeat (20) step();
    idle();
    @(negedge clk);
    chk("stall saturation", int'(stall_count), 15);

    // Randomized traffic, checked every cycle by the model
    for (int c = 0; c < 3000; c++) begin
      step();
      if (m_err) begin
        do_reset();
        busy_left = 0;
      end
      id_rs = 5'($urandom_range(0, 3));
      id_rt = 5'($urandom_range(0, 3));
      ex_rs = 5'($urandom_range(0, 3));
      ex_rt = 5'($urandom_range(0, 3));
      ex_rt_dst = 5'($urandom_range(0, 3));
      exm_wr_reg = 5'($urandom_range(0, 3));
      mwb_wr_reg = 5'($urandom_range(0, 3));
      ex_mem_read = ($urandom_range(0, 2) == 0);
      exm_reg_write = 1'($urandom_range(0, 1));
      mwb_reg_write = 1'($urandom_range(0, 1));
      pc_src = ($urandom_range(0, 5) == 0);
      if (busy_left == 0 && $urandom_range(0, 15) == 0) busy_left = $urandom_range(1, 10);
      mem_busy = (busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
    step();
    idle();
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard and pipeline-control unit for the 5-stage MIPS pipeline; it supersedes the stand-alone forwarding unit. It combines EX-stage operand forwarding, load-use interlock, branch flush and whole-pipeline freeze on a busy data memory into one block. It drives per-stage enable and flush strobes, and keeps saturating stall and flush counters. It sits beside the stage modules in the pipeline top, fed from the IF/ID, ID/EX, EX/MEM and MEM/WB registers.

## Interface
- REG_AW, 5: register-address width.
- CNT_W, 16: width of the performance counters.
- MAX_WAIT, 64: consecutive mem_busy cycles tolerated before timeout (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low (one clock domain).
- id_rs, id_rt  in  REG_AW  source fields of the instruction in IF/ID.
- ex_rs, ex_rt  in  REG_AW  source fields held in ID/EX.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_rt_dst  in  REG_AW  load destination (rt) held in ID/EX.
- exm_reg_write, exm_wr_reg  in  1, REG_AW  EX/MEM RegWrite and destination.
- mwb_reg_write, mwb_wr_reg  in  1, REG_AW  MEM/WB RegWrite and destination.
- pc_src  in  1  branch taken, resolved in MEM.
- mem_busy  in  1  data memory not ready this cycle.
- forward_a_sel, forward_b_sel  out  2  00 = register file, 10 = EX/MEM ALU result, 01 = MEM/WB write-back data.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  stage register load enables.
- if_id_flush, id_ex_flush, ex_mem_flush  out  1  load a bubble (all control bits 0).
- mem_timeout  out  1  sticky error flag.
- stall_count, flush_count  out  CNT_W  saturating counters.

## Operation
**Forwarding** (combinational):
- forward_a_sel = 10 when exm_reg_write, exm_wr_reg≠0 and exm_wr_reg==ex_rs.
- Otherwise 01 when mwb_reg_write, mwb_wr_reg≠0 and mwb_wr_reg==ex_rs.
- Otherwise 00.
- forward_b_sel follows the same rules with ex_rt.
- EX/MEM has priority over MEM/WB. Register 0 is never forwarded.

**Load-use hazard** (lu):
- lu = ex_mem_read && ex_rt_dst≠0 && (ex_rt_dst==id_rs || ex_rt_dst==id_rt).
- Response: pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle.

**FSM states:** RUN, WAIT, ERR.
- RUN with mem_busy=0: all enables 1, except during lu.
  - Flush applies when pc_src=1 or pend_flush=1. It drives if_id_flush, id_ex_flush and ex_mem_flush to 1 and clears pend_flush.
  - Flush overrides lu: no stall is asserted and pc_en=1, so the branch target loads.
- RUN with mem_busy=1: go to WAIT. All enables and flushes are 0 in that same cycle.
- WAIT: all enables and flushes are 0.
  - wait_cnt increments each cycle.
  - pc_src=1 sets pend_flush.
  - mem_busy=0 returns the FSM to RUN; wait_cnt clears.
  - wait_cnt reaching MAX_WAIT-1 while still busy goes to ERR.
- ERR: all enables 0, mem_timeout=1. Only rst_n leaves ERR.

**Counters:**
- stall_count increments each cycle pc_en=0 while not in ERR.
- flush_count increments each cycle a flush is applied.
- Both saturate at 2^CNT_W−1 and do not wrap.

## Timing
- Forwarding, enables and flushes are combinational from the inputs and the current state, so zero-cycle response.
- State, wait_cnt, pend_flush, mem_timeout and the counters update on the rising edge of clk.
- Reset state: RUN, wait_cnt=0, pend_flush=0, mem_timeout=0, both counters 0.
- Outputs during and immediately after reset (inputs idle): all enables 1, all flushes 0, forward selects 00.
- Load-use costs exactly 1 bubble. Branch flush costs 3 squashed slots.
- The freeze starts in the first busy cycle and ends in the first non-busy cycle.
- A branch seen in WAIT is flushed in the first RUN cycle.
- pc_src and mem_busy together in RUN: the freeze wins and pend_flush is set.
- Reset asserted mid-WAIT or in ERR: the FSM returns to RUN immediately (asynchronously) and pending state is cleared.

## Test plan
- Forwarding with ex_rs=3: exm_wr_reg=3 and mwb_wr_reg=3, both RegWrite → forward_a_sel=10. Drop exm_reg_write → 01. Set the destination to 0 → 00.
- Load-use: ex_mem_read=1, ex_rt_dst=5, id_rt=5 → pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_count 0→1.
- Branch flush: pc_src=1 in RUN → all three flushes 1 for one cycle; flush_count=1. With lu also true → pc_en stays 1.
- Memory freeze: mem_busy high 4 cycles with pc_src pulsed in cycle 2 → all enables 0 for 4 cycles. The first RUN cycle flushes; stall_count=4, flush_count=1.
- Timeout with MAX_WAIT=8 and mem_busy held high → after 8 cycles mem_timeout=1 and enables stay 0. Assert rst_n=0 → state RUN, counters 0, mem_timeout 0.
- Saturation with CNT_W=4 and 20 load-use stalls → stall_count holds at 15.
